uart_flash_packet_tx: RTL

- Transmit-side counterpart of the UART memflash command path.
- Accepts one command packet (cmd byte plus up to MAX_DATA_BYTES payload bytes) over a valid/ready handshake.
- Frames the packet as sync, cmd, len and payload bytes, then serializes each byte as 8N1 UART on tx_out.
- Used for board-to-host telemetry (camera/scene readback, frame-done reports) and as a loopback stimulus source for the memflash receiver.

---
 rtl/uart_pkt_pkg.sv | 46 ++++
 rtl/uart_flash_packet_tx_if.sv | 33 +++
 rtl/uart_byte_tx.sv | 70 +++++++
 rtl/uart_flash_packet_tx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkt_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkt_pkg
// Shared definitions for the UART memflash packet path (transmitter here,
// receiver elsewhere): default framing constants, the packet FSM state type
// and the command codes both ends agree on.
//
// Configuration macro: UART_PKT_CHECKSUM_EN adds the CSUM state to the
// packet state type.
// ----------------------------------------------------------------------------
package uart_pkt_pkg;

    // First byte of every packet; the receiver hunts for it to find frame start.
    localparam logic [7:0] SYNC_BYTE_DEFAULT      = 8'hA5;
    localparam int         MAX_DATA_BYTES_DEFAULT = 16;

    // Command codes shared with the memflash receiver.
    localparam logic [7:0] CMD_PING       = 8'h00;
    localparam logic [7:0] CMD_ERASE      = 8'h01;
    localparam logic [7:0] CMD_WRITE      = 8'h02;
    localparam logic [7:0] CMD_READ       = 8'h03;
    localparam logic [7:0] CMD_STATUS     = 8'h04;
    localparam logic [7:0] CMD_SCENE_LOAD = 8'h05;
    localparam logic [7:0] CMD_FRAME_DONE = 8'h06;
    localparam logic [7:0] CMD_CAM_READ   = 8'h07;
    localparam logic [7:0] CMD_RESET      = 8'h08;
    localparam logic [7:0] CMD_VERSION    = 8'h09;

    // Each non-IDLE/DONE state names the byte currently on the wire.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_CMD  = 3'd2,
        ST_LEN  = 3'd3,
        ST_DATA = 3'd4,
`ifdef UART_PKT_CHECKSUM_EN
        ST_CSUM = 3'd5,
`endif
        ST_DONE = 3'd6
    } pkt_state_t;

    // Cycles per UART bit; integer division, so the line rate rounds up slightly.
    function automatic int calc_baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_flash_packet_tx_if.sv
// ----------------------------------------------------------------------------
// uart_flash_packet_tx_if
// Packet offer handshake into the UART packet transmitter.
//   pkt_valid  master->slave  packet offered
//   pkt_ready  slave->master  transmitter idle and able to accept
//   pkt_cmd    master->slave  command byte
//   pkt_len    master->slave  payload byte count (clamped by the slave)
//   pkt_data   master->slave  payload, byte 0 in bits [7:0], sent first
// ----------------------------------------------------------------------------
interface uart_flash_packet_tx_if
    import uart_pkt_pkg::*;
#(
    parameter int MAX_DATA_BYTES = MAX_DATA_BYTES_DEFAULT
);
    localparam int LEN_W = $clog2(MAX_DATA_BYTES + 1);

    logic                        pkt_valid;
    logic                        pkt_ready;
    logic [7:0]                  pkt_cmd;
    logic [LEN_W-1:0]            pkt_len;
    logic [MAX_DATA_BYTES*8-1:0] pkt_data;

    modport master (
        output pkt_valid, pkt_cmd, pkt_len, pkt_data,
        input  pkt_ready
    );

    modport slave (
        input  pkt_valid, pkt_cmd, pkt_len, pkt_data,
        output pkt_ready
    );

endinterface

// File: rtl/uart_byte_tx.sv
// ----------------------------------------------------------------------------
// uart_byte_tx
// 8N1 UART byte serializer. One frame = start(0), 8 data bits LSB first,
// stop(1), each bit held BAUD_DIV cycles.
//   clk, rst    clock, synchronous active-high reset
//   byte_valid  byte offered by the packet FSM
//   byte_data   byte to send
//   byte_ready  idle, or in the final cycle of a stop bit (so a new byte
//               can follow with no idle gap)
//   tx_out      serial line, idles high
// ----------------------------------------------------------------------------
module uart_byte_tx #(
    parameter int BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       tx_out
);
    localparam int               CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    logic             active;
    logic [CNT_W-1:0] baud_cnt;
    logic [3:0]       bit_idx;
    logic [8:0]       shift_q;
    logic             bit_end;
    logic             frame_end;

    assign bit_end    = (baud_cnt == CNT_LAST);
    assign frame_end  = active && bit_end && (bit_idx == 4'd9);
    // Ready during the last stop cycle lets the next start bit follow immediately.
    assign byte_ready = !active || frame_end;

    // Bit index 0 is the start bit, 1..8 data, 9 stop. shift_q holds the bits
    // still to go out (data then stop), so tx_out always takes shift_q[0].
    always_ff @(posedge clk) begin
        if (rst) begin
            active   <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift_q  <= '1;
            tx_out   <= 1'b1;
        end else if (byte_valid && byte_ready) begin
            active   <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift_q  <= {1'b1, byte_data};
            tx_out   <= 1'b0;
        end else if (active) begin
            if (bit_end) begin
                baud_cnt <= '0;
                if (bit_idx == 4'd9) begin
                    active  <= 1'b0;
                    bit_idx <= '0;
                    tx_out  <= 1'b1;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    tx_out  <= shift_q[0];
                    shift_q <= {1'b1, shift_q[8:1]};
                end
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_flash_packet_tx.sv
// ----------------------------------------------------------------------------
// uart_flash_packet_tx
// Accepts one command packet and sends it as SYNC, CMD, LEN, DATA[0..len-1]
// (and CSUM when enabled), each byte as an 8N1 UART frame on tx_out.
//   clk, rst   clock, synchronous active-high reset
//   pkt        packet handshake (slave modport): valid/ready, cmd, len, data
//   pkt_done   one-cycle pulse after the last stop bit completes
//   busy       high from acceptance until pkt_done
//   tx_out     serial line, idles high
//
// Configuration macro: UART_PKT_CHECKSUM_EN appends CSUM = XOR of cmd, len
// and payload bytes (SYNC excluded).
// ----------------------------------------------------------------------------
module uart_flash_packet_tx
    import uart_pkt_pkg::*;
#(
    parameter int         CLK_HZ         = 100_000_000,
    parameter int         BAUD           = 115_200,
    parameter int         MAX_DATA_BYTES = MAX_DATA_BYTES_DEFAULT,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_flash_packet_tx_if.slave  pkt,
    output logic                   pkt_done,
    output logic                   busy,
    output logic                   tx_out
);
    localparam int               BAUD_DIV = calc_baud_div(CLK_HZ, BAUD);
    localparam int               LEN_W    = $clog2(MAX_DATA_BYTES + 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_DATA_BYTES);

    pkt_state_t                  state;
    logic                        pkt_ready_q;
    logic [7:0]                  cmd_q;
    logic [LEN_W-1:0]            len_q;
    logic [LEN_W-1:0]            rem_q;
    logic [MAX_DATA_BYTES*8-1:0] data_q;
`ifdef UART_PKT_CHECKSUM_EN
    logic [7:0]                  csum_q;
`endif

    logic [LEN_W-1:0] len_clamped;
    logic             accept;
    logic             last_data;
    logic             ser_valid;
    logic [7:0]       ser_data;
    logic             ser_ready;

    assign pkt.pkt_ready = pkt_ready_q;
    assign len_clamped   = (pkt.pkt_len > LEN_MAX) ? LEN_MAX : pkt.pkt_len;
    assign accept        = (state == ST_IDLE) && pkt.pkt_valid && pkt_ready_q;
    // rem_q counts payload bytes still to follow the one on the wire.
    assign last_data     = (rem_q == '0);

    // Picks the byte to hand the serializer. The SYNC byte is offered in the
    // acceptance cycle itself so the start bit appears on the very next
    // cycle; every later byte is offered in its predecessor's final stop
    // cycle, when the serializer reports ready.
    always_comb begin
        ser_valid = 1'b0;
        ser_data  = SYNC_BYTE;
        case (state)
            ST_IDLE: begin
                ser_valid = accept;
                ser_data  = SYNC_BYTE;
            end
            ST_SYNC: begin
                ser_valid = ser_ready;
                ser_data  = cmd_q;
            end
            ST_CMD: begin
                ser_valid = ser_ready;
                ser_data  = 8'(len_q);
            end
            ST_LEN: begin
                if (len_q != '0) begin
                    ser_valid = ser_ready;
                    ser_data  = data_q[7:0];
                end else begin
`ifdef UART_PKT_CHECKSUM_EN
                    ser_valid = ser_ready;
                    ser_data  = csum_q;
`endif
                end
            end
            ST_DATA: begin
                if (!last_data) begin
                    ser_valid = ser_ready;
                    ser_data  = data_q[7:0];
                end else begin
`ifdef UART_PKT_CHECKSUM_EN
                    ser_valid = ser_ready;
                    ser_data  = csum_q;
`endif
                end
            end
            default: begin
                ser_valid = 1'b0;
            end
        endcase
    end

    // Packet FSM. The payload register shifts right one byte each time a
    // payload byte is handed over, so the next one is always in data_q[7:0].
    // The running checksum folds in each payload byte at the same moment.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pkt_ready_q <= 1'b0;
            busy        <= 1'b0;
            pkt_done    <= 1'b0;
            cmd_q       <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            data_q      <= '0;
`ifdef UART_PKT_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            pkt_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    pkt_ready_q <= 1'b1;
                    if (accept) begin
                        cmd_q       <= pkt.pkt_cmd;
                        len_q       <= len_clamped;
                        data_q      <= pkt.pkt_data;
`ifdef UART_PKT_CHECKSUM_EN
                        csum_q      <= pkt.pkt_cmd ^ 8'(len_clamped);
`endif
                        busy        <= 1'b1;
                        pkt_ready_q <= 1'b0;
                        state       <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (ser_ready) state <= ST_CMD;
                end
                ST_CMD: begin
                    if (ser_ready) state <= ST_LEN;
                end
                ST_LEN: begin
                    if (ser_ready) begin
                        if (len_q != '0) begin
                            rem_q  <= len_q - 1'b1;
                            data_q <= data_q >> 8;
`ifdef UART_PKT_CHECKSUM_EN
                            csum_q <= csum_q ^ data_q[7:0];
`endif
                            state  <= ST_DATA;
                        end else begin
`ifdef UART_PKT_CHECKSUM_EN
                            state    <= ST_CSUM;
`else
                            state    <= ST_DONE;
                            pkt_done <= 1'b1;
`endif
                        end
                    end
                end
                ST_DATA: begin
                    if (ser_ready) begin
                        if (!last_data) begin
                            rem_q  <= rem_q - 1'b1;
                            data_q <= data_q >> 8;
`ifdef UART_PKT_CHECKSUM_EN
                            csum_q <= csum_q ^ data_q[7:0];
`endif
                        end else begin
`ifdef UART_PKT_CHECKSUM_EN
                            state    <= ST_CSUM;
`else
                            state    <= ST_DONE;
                            pkt_done <= 1'b1;
`endif
                        end
                    end
                end
`ifdef UART_PKT_CHECKSUM_EN
                ST_CSUM: begin
                    if (ser_ready) begin
                        state    <= ST_DONE;
                        pkt_done <= 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    busy        <= 1'b0;
                    pkt_ready_q <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    uart_byte_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_byte_tx (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (ser_valid),
        .byte_data  (ser_data),
        .byte_ready (ser_ready),
        .tx_out     (tx_out)
    );

endmodule
